dram_burst_engine: RTL and testbench
====================================

Name: dram_burst_engine

Overview:
Parametrised single-clock successor to the DRAM data-transfer path. It serialises a full burst line onto the DQ bus with programmable write latency, strobe preamble/postamble and per-byte data mask, and it deserialises read beats into a line buffer with a valid qualifier and timeout. It supports full bursts and burst chop (BURST/2). It sits between the DRAM controller FSM (start/busy/done handshake) and the pad/PHY layer (output enables, strobe qualifier).

Parameters:
DQ_W, 32, DQ data width in bits; multiple of 8.
BURST, 8, beats per full burst; power of 2, at least 4.
LAT_W, 4, width of runtime latency inputs.
TIMEOUT, 16, consecutive idle capture cycles before read abort; at least 1.

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
wr_start  in  1  start write burst; sampled in IDLE only
rd_start  in  1  start read burst; sampled in IDLE only
bl_chop  in  1  1 selects a BURST/2 burst
col_sel  in  log2(BURST)  target word within the line
wl  in  LAT_W  write latency in cycles (0 allowed)
rl  in  LAT_W  read latency in cycles (0 allowed)
word_only  in  1  1 masks every beat except col_sel
wr_be  in  DQ_W/8  byte enables for the target beat
wr_line  in  BURST*DQ_W  write line; word i in bits [i*DQ_W +: DQ_W]
dq_out  out  DQ_W  write beat data
dq_oe  out  1  DQ output enable
dm_n  out  DQ_W/8  data mask, active-low (1 = write byte)
dqs_t  out  1  strobe true
dqs_c  out  1  strobe complement
dqs_oe  out  1  strobe output enable
dq_in  in  DQ_W  read beat data
dq_in_valid  in  1  read beat qualifier from the PHY strobe capture
rd_line  out  BURST*DQ_W  assembled read line
rd_word  out  DQ_W  rd_line word col_sel
rd_valid  out  1  1-cycle pulse: read line complete
busy  out  1  burst in progress
done  out  1  1-cycle pulse: burst finished
err  out  1  1-cycle pulse: read timeout

Behaviour:
- Reset: RST high at a rising edge drives the FSM to IDLE and all outputs and registers to 0, including rd_line. Reset mid-burst aborts the burst the next cycle with oe=0 and no done/err.
- States: IDLE, WR_LAT, WR_PRE, WR_DATA, WR_POST, RD_LAT, RD_CAP, FIN.
- IDLE: a wr_start at cycle T latches wr_line, col_sel, wl, bl_chop, word_only and wr_be. If wr_start and rd_start are both high, write wins and rd_start is dropped. Start pulses outside IDLE are ignored. busy=1 from T+1 until FIN.
- N = bl_chop ? BURST/2 : BURST. Start beat S = bl_chop ? (col_sel MSB)*BURST/2 : 0. Sent or captured words are S..S+N-1.
- Write sequence:
  - WR_LAT lasts wl cycles (skipped when wl=0).
  - WR_PRE lasts 1 cycle: dqs_oe=1, dqs_t=0, dq_oe=0.
  - WR_DATA lasts N cycles: dq_oe=dqs_oe=1, dq_out = word S+k on beat k, dqs_t=1 on even k and 0 on odd k.
  - dm_n: if word_only=0, all ones on every beat. If word_only=1, wr_be on the col_sel beat and 0 on all other beats.
  - WR_POST lasts 1 cycle: dqs_oe=1, dqs_t=0, dq_oe=0.
  - Timing: first beat at T+wl+2; done at T+wl+N+3.
- Strobe complement: dqs_c = dqs_oe & ~dqs_t.
- Idle bus values: when dq_oe=0, dq_out=0 and dm_n=0. When dqs_oe=0, dqs_t=0.
- Read sequence:
  - RD_LAT lasts rl cycles.
  - RD_CAP samples dq_in only when dq_in_valid=1 and stores it in word S+k, then k increments. Invalid cycles hold.
  - After the Nth valid beat at cycle C, FIN is at C+1: rd_valid=1, done=1.
  - dq_in_valid outside RD_CAP is ignored.
  - Words outside S..S+N-1 keep their prior value.
  - rd_line holds until the next capture overwrites it.
  - rd_word is combinational from rd_line and the latched col_sel.
- Read timeout: a counter of consecutive invalid cycles in RD_CAP resets on every valid beat. When it reaches TIMEOUT, FIN asserts err=1 and done=1 with rd_valid=0.
- FIN: busy=0. done and rd_valid/err pulse for 1 cycle. A start in FIN is accepted, giving back-to-back bursts.

Test Plan:
- Reset: hold RST 2 cycles mid-write (wl=0) -> next cycle dq_oe=dqs_oe=busy=0 and done never asserts.
- Write, DQ_W=32, BURST=8, wl=2, col_sel=3, word_only=1, wr_be=4'hF, wr_line words 0x1000_000i, start at T -> preamble at T+3; dq_out=0x1000_0000..0x1000_0007 at T+4..T+11; dm_n=F only at T+7, otherwise 0; dqs_t 1,0,1,...; postamble at T+12; done at T+13.
- Chopped write, col_sel=5, wl=0 -> beats words 4..7 at T+2..T+5; dm_n=F at T+3; done at T+7.
- Read rl=3, 8 valid beats 0xA0..0xA7 with one invalid gap after beat 2 -> rd_line word i = 0xA0+i; rd_word=0xA3 for col_sel=3; rd_valid and done high for 1 cycle after the 8th beat; err=0.
- Read timeout: 5 valid beats, then dq_in_valid=0 for 16 cycles -> err=done=1 on the cycle after the 16th idle cycle; rd_valid stays 0; busy drops.
- Simultaneous wr_start and rd_start in IDLE -> write executes and no read occurs; a rd_start during busy is ignored; a rd_start in the FIN cycle starts the read.

Source files
------------

// File: rtl/dram_burst_engine.sv
// Single-clock DRAM burst data path: serialises a write line onto DQ with strobe
// pre/postamble and data mask, and assembles read beats into a line with timeout.
module dram_burst_engine #(
  parameter int DQ_W    = 32,
  parameter int BURST   = 8,
  parameter int LAT_W   = 4,
  parameter int TIMEOUT = 16
)(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  wr_start,
  input  logic                  rd_start,
  input  logic                  bl_chop,
  input  logic [$clog2(BURST)-1:0] col_sel,
  input  logic [LAT_W-1:0]      wl,
  input  logic [LAT_W-1:0]      rl,
  input  logic                  word_only,
  input  logic [DQ_W/8-1:0]     wr_be,
  input  logic [BURST*DQ_W-1:0] wr_line,
  output logic [DQ_W-1:0]       dq_out,
  output logic                  dq_oe,
  output logic [DQ_W/8-1:0]     dm_n,
  output logic                  dqs_t,
  output logic                  dqs_c,
  output logic                  dqs_oe,
  input  logic [DQ_W-1:0]       dq_in,
  input  logic                  dq_in_valid,
  output logic [BURST*DQ_W-1:0] rd_line,
  output logic [DQ_W-1:0]       rd_word,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int CW = $clog2(BURST);
  localparam int BW = DQ_W/8;
  localparam int TW = $clog2(TIMEOUT+1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_LAT  = 3'd1;
  localparam logic [2:0] WR_PRE  = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] WR_POST = 3'd4;
  localparam logic [2:0] RD_LAT  = 3'd5;
  localparam logic [2:0] RD_CAP  = 3'd6;
  localparam logic [2:0] FIN     = 3'd7;

  logic [2:0]                  state;
  logic [BURST-1:0][DQ_W-1:0]  wr_q, cap_q;
  logic [CW-1:0]               col_q, beat;
  logic [LAT_W-1:0]            lat_cnt;
  logic                        chop_q, wo_q;
  logic [BW-1:0]               be_q;
  logic [TW-1:0]               idle_cnt;
  logic                        fin_rd, fin_err;
  logic [CW-1:0]               start_beat, last_beat, word_idx;

  // Chopped bursts cover the half of the line that holds the target word
  assign start_beat = chop_q ? {col_q[CW-1], {(CW-1){1'b0}}} : '0;
  assign last_beat  = chop_q ? CW'(BURST/2-1) : CW'(BURST-1);
  assign word_idx   = start_beat + beat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      wr_q     <= '0;
      cap_q    <= '0;
      col_q    <= '0;
      beat     <= '0;
      lat_cnt  <= '0;
      chop_q   <= 1'b0;
      wo_q     <= 1'b0;
      be_q     <= '0;
      idle_cnt <= '0;
      fin_rd   <= 1'b0;
      fin_err  <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          // write wins a tie; FIN accepts a start for back-to-back bursts
          if (wr_start) begin
            state   <= (wl == '0) ? WR_PRE : WR_LAT;
            lat_cnt <= wl - 1'b1;
            wr_q    <= wr_line;
            col_q   <= col_sel;
            chop_q  <= bl_chop;
            wo_q    <= word_only;
            be_q    <= wr_be;
          end else if (rd_start) begin
            state    <= (rl == '0) ? RD_CAP : RD_LAT;
            lat_cnt  <= rl - 1'b1;
            col_q    <= col_sel;
            chop_q   <= bl_chop;
            beat     <= '0;
            idle_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        WR_LAT: begin
          if (lat_cnt == '0) state <= WR_PRE;
          else lat_cnt <= lat_cnt - 1'b1;
        end
        WR_PRE: begin
          state <= WR_DATA;
          beat  <= '0;
        end
        WR_DATA: begin
          if (beat == last_beat) state <= WR_POST;
          else beat <= beat + 1'b1;
        end
        WR_POST: begin
          state   <= FIN;
          fin_rd  <= 1'b0;
          fin_err <= 1'b0;
        end
        RD_LAT: begin
          if (lat_cnt == '0) state <= RD_CAP;
          else lat_cnt <= lat_cnt - 1'b1;
        end
        RD_CAP: begin
          if (dq_in_valid) begin
            cap_q[word_idx] <= dq_in;
            idle_cnt        <= '0;
            if (beat == last_beat) begin
              state   <= FIN;
              fin_rd  <= 1'b1;
              fin_err <= 1'b0;
            end else begin
              beat <= beat + 1'b1;
            end
          end else if (idle_cnt == TW'(TIMEOUT-1)) begin
            state   <= FIN;
            fin_rd  <= 1'b1;
            fin_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    dq_out = '0;
    dq_oe  = 1'b0;
    dm_n   = '0;
    dqs_t  = 1'b0;
    dqs_oe = 1'b0;
    case (state)
      WR_PRE, WR_POST: dqs_oe = 1'b1;
      WR_DATA: begin
        dq_oe  = 1'b1;
        dqs_oe = 1'b1;
        dqs_t  = ~beat[0];
        dq_out = wr_q[word_idx];
        dm_n   = !wo_q ? '1 : ((word_idx == col_q) ? be_q : '0);
      end
      default: ;
    endcase
  end

  assign dqs_c    = dqs_oe & ~dqs_t;
  assign busy     = (state != IDLE) && (state != FIN);
  assign done     = (state == FIN);
  assign rd_valid = done & fin_rd & ~fin_err;
  assign err      = done & fin_err;
  assign rd_line  = cap_q;
  assign rd_word  = cap_q[col_q];
endmodule

// File: tb/tb_dram_burst_engine.sv
// Scoreboard bench for dram_burst_engine: the driver predicts strobe-window beats
// and burst completions from the burst rules; a negedge monitor pops and compares.
module tb_dram_burst_engine;
  localparam int DQ_W = 32, BURST = 8, LAT_W = 4, TIMEOUT = 16;
  localparam int BW = DQ_W/8, CW = $clog2(BURST), LW = BURST*DQ_W;

  logic CLK = 1'b0, RST = 1'b1;
  logic wr_start = 1'b0, rd_start = 1'b0, bl_chop = 1'b0, word_only = 1'b0, dq_in_valid = 1'b0;
  logic [CW-1:0]    col_sel = '0;
  logic [LAT_W-1:0] wl = '0, rl = '0;
  logic [BW-1:0]    wr_be = '0;
  logic [LW-1:0]    wr_line = '0;
  logic [DQ_W-1:0]  dq_in = '0;
  logic [DQ_W-1:0]  dq_out, rd_word;
  logic [BW-1:0]    dm_n;
  logic [LW-1:0]    rd_line;
  logic dq_oe, dqs_t, dqs_c, dqs_oe, rd_valid, busy, done, err;

  dram_burst_engine #(.DQ_W(DQ_W), .BURST(BURST), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .wr_start(wr_start), .rd_start(rd_start), .bl_chop(bl_chop),
    .col_sel(col_sel), .wl(wl), .rl(rl), .word_only(word_only), .wr_be(wr_be),
    .wr_line(wr_line), .dq_out(dq_out), .dq_oe(dq_oe), .dm_n(dm_n), .dqs_t(dqs_t),
    .dqs_c(dqs_c), .dqs_oe(dqs_oe), .dq_in(dq_in), .dq_in_valid(dq_in_valid),
    .rd_line(rd_line), .rd_word(rd_word), .rd_valid(rd_valid), .busy(busy),
    .done(done), .err(err));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0, bad = 0;
  bit mon_en = 1'b0;

  typedef struct { int cyc; logic oe; logic t; logic [DQ_W-1:0] dq; logic [BW-1:0] dm; } beat_t;
  typedef struct { int cyc; logic rv; logic er; logic [LW-1:0] line; logic [DQ_W-1:0] word; } fin_t;
  beat_t bq[$];
  fin_t  fq[$];
  logic [DQ_W-1:0] mline [BURST];

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack_line();
    logic [LW-1:0] r;
    for (int i = 0; i < BURST; i++) r[i*DQ_W +: DQ_W] = mline[i];
    return r;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < BURST; i++) r[i*DQ_W +: DQ_W] = $urandom;
    return r;
  endfunction

  task automatic next_cyc();
    @(posedge CLK);
    #1;
  endtask

  // churn inputs that the DUT must have latched or must ignore while busy
  task automatic churn();
    rd_start    = 1'($urandom_range(0, 1));
    dq_in_valid = 1'($urandom_range(0, 1));
    dq_in       = $urandom;
    col_sel     = CW'($urandom);
    wl          = LAT_W'($urandom);
    rl          = LAT_W'($urandom);
    bl_chop     = 1'($urandom_range(0, 1));
    word_only   = 1'($urandom_range(0, 1));
    wr_be       = BW'($urandom);
    wr_line     = rand_line();
  endtask

  always @(negedge CLK) begin : mon
    beat_t b;
    fin_t  f;
    if (mon_en) begin
      chk("dqs_c", LW'(dqs_c), LW'(dqs_oe & ~dqs_t));
      if (!dq_oe) chk("idle_bus", LW'({dq_out, dm_n}), '0);
      if (!dqs_oe) chk("idle_dqs", LW'({dq_oe, dqs_t}), '0);
      else if (bq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexp_strobe cycle %0d: got dqs_oe=1 want 0", cyc);
      end else begin
        b = bq.pop_front();
        chk("beat_cyc", LW'(cyc), LW'(b.cyc));
        chk("beat_oe", LW'(dq_oe), LW'(b.oe));
        chk("beat_dqs_t", LW'(dqs_t), LW'(b.t));
        chk("beat_dq", LW'(dq_out), LW'(b.dq));
        chk("beat_dm_n", LW'(dm_n), LW'(b.dm));
      end
      if (done) begin
        if (fq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexp_done cycle %0d: got done=1 want 0", cyc);
        end else begin
          f = fq.pop_front();
          chk("fin_cyc", LW'(cyc), LW'(f.cyc));
          chk("rd_valid", LW'(rd_valid), LW'(f.rv));
          chk("err", LW'(err), LW'(f.er));
          chk("rd_line", rd_line, f.line);
          chk("rd_word", LW'(rd_word), LW'(f.word));
          chk("busy_fin", LW'(busy), '0);
        end
      end else begin
        chk("pulse_idle", LW'({rd_valid, err}), '0);
      end
    end
  end

  task automatic do_write(input int wlv, input bit ch, input int col, input bit wo,
                          input logic [BW-1:0] be, input logic [LW-1:0] ln, input bit also_rd);
    int T, N, S, w, td;
    beat_t b;
    fin_t f;
    T = cyc;
    N = ch ? BURST/2 : BURST;
    S = ch ? ((col >> (CW-1)) & 1) * (BURST/2) : 0;
    b.cyc = T + wlv + 1; b.oe = 1'b0; b.t = 1'b0; b.dq = '0; b.dm = '0;
    bq.push_back(b);
    for (int k = 0; k < N; k++) begin
      w = S + k;
      b.cyc = T + wlv + 2 + k;
      b.oe  = 1'b1;
      b.t   = (k % 2 == 0);
      b.dq  = ln[w*DQ_W +: DQ_W];
      b.dm  = wo ? ((w == col) ? be : '0) : '1;
      bq.push_back(b);
    end
    b.cyc = T + wlv + N + 2; b.oe = 1'b0; b.t = 1'b0; b.dq = '0; b.dm = '0;
    bq.push_back(b);
    td = T + wlv + N + 3;
    f.cyc = td; f.rv = 1'b0; f.er = 1'b0; f.line = pack_line(); f.word = mline[col];
    fq.push_back(f);
    wr_start = 1'b1; rd_start = also_rd; wl = LAT_W'(wlv); bl_chop = ch;
    col_sel = CW'(col); word_only = wo; wr_be = be; wr_line = ln;
    dq_in_valid = 1'($urandom_range(0, 1));
    next_cyc();
    wr_start = 1'b0;
    chk("busy_start", LW'(busy), LW'(1));
    while (cyc < td) begin
      churn();
      next_cyc();
    end
    rd_start = 1'b0; dq_in_valid = 1'b0;
  endtask

  task automatic do_read(input int rlv, input bit ch, input int col, input int tmo_after, input bit dir);
    int T, N, S, k, idle, td;
    bit v, gapped, fer;
    logic [DQ_W-1:0] d;
    fin_t f;
    T = cyc;
    N = ch ? BURST/2 : BURST;
    S = ch ? ((col >> (CW-1)) & 1) * (BURST/2) : 0;
    rd_start = 1'b1; wr_start = 1'b0; rl = LAT_W'(rlv); bl_chop = ch; col_sel = CW'(col);
    dq_in_valid = 1'($urandom_range(0, 1)); dq_in = $urandom;
    next_cyc();
    rd_start = 1'b0;
    chk("busy_start", LW'(busy), LW'(1));
    while (cyc < T + rlv + 1) begin
      churn();
      next_cyc();
    end
    k = 0; idle = 0; td = 0; gapped = 1'b0; fer = 1'b0;
    while (td == 0) begin
      churn();
      if (tmo_after >= 0 && k == tmo_after) v = 1'b0;
      else if (dir) begin
        v = !(k == 3 && !gapped);
        if (!v) gapped = 1'b1;
      end else v = (idle == TIMEOUT-1) || ($urandom_range(0, 3) != 0);
      d = dir ? DQ_W'(32'hA0 + k) : DQ_W'($urandom);
      dq_in_valid = v; dq_in = d;
      if (v) begin
        mline[S+k] = d;
        k++; idle = 0;
        if (k == N) begin td = cyc + 1; fer = 1'b0; end
      end else begin
        idle++;
        if (idle == TIMEOUT) begin td = cyc + 1; fer = 1'b1; end
      end
      if (td != 0) begin
        f.cyc = td; f.rv = !fer; f.er = fer; f.line = pack_line(); f.word = mline[col];
        fq.push_back(f);
      end
      next_cyc();
    end
    rd_start = 1'b0; dq_in_valid = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    wr_start = 1'b0; rd_start = 1'b0; dq_in_valid = 1'b0;
    repeat (n) next_cyc();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish by cycle %0d want finish", cyc);
    $fatal(1);
  end

  initial begin
    logic [LW-1:0] ln;
    int ch, col;
    for (int i = 0; i < BURST; i++) mline[i] = '0;
    repeat (3) next_cyc();
    chk("rst_busy_done", LW'({busy, done, rd_valid, err}), '0);
    chk("rst_oe", LW'({dq_oe, dqs_oe, dqs_t, dqs_c}), '0);
    chk("rst_bus", LW'({dq_out, dm_n}), '0);
    chk("rst_rd_line", rd_line, '0);
    chk("rst_rd_word", LW'(rd_word), '0);
    RST = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < BURST; i++) ln[i*DQ_W +: DQ_W] = 32'h1000_0000 + i;
    do_write(2, 1'b0, 3, 1'b1, 4'hF, ln, 1'b1);
    do_write(0, 1'b1, 5, 1'b1, 4'hF, rand_line(), 1'b0);
    do_read(3, 1'b0, 3, -1, 1'b1);
    idle_gap(2);
    do_read(2, 1'b0, $urandom_range(0, BURST-1), 5, 1'b0);
    do_write(1, 1'b0, 6, 1'b0, 4'h5, rand_line(), 1'b0);
    do_read(0, 1'b1, 2, -1, 1'b0);

    repeat (40) begin
      idle_gap($urandom_range(0, 2));
      ch  = $urandom_range(0, 1);
      col = $urandom_range(0, BURST-1);
      if ($urandom_range(0, 1) != 0)
        do_write($urandom_range(0, 5), 1'(ch), col, 1'($urandom_range(0, 1)), BW'($urandom),
                 rand_line(), 1'($urandom_range(0, 1)));
      else
        do_read($urandom_range(0, 5), 1'(ch), col,
                ($urandom_range(0, 4) == 0) ? $urandom_range(0, (ch != 0 ? BURST/2 : BURST) - 1) : -1,
                1'b0);
    end

    idle_gap(1);
    chk("beats_drained", LW'(bq.size()), '0);
    chk("fins_drained", LW'(fq.size()), '0);
    mon_en = 1'b0;

    wr_start = 1'b1; wl = '0; bl_chop = 1'b0; word_only = 1'b0; wr_line = rand_line();
    next_cyc();
    wr_start = 1'b0;
    repeat (3) next_cyc();
    chk("pre_rst_oe", LW'(dq_oe), LW'(1));
    RST = 1'b1;
    repeat (2) next_cyc();
    RST = 1'b0;
    chk("rst_mid_oe", LW'({dq_oe, dqs_oe}), '0);
    chk("rst_mid_busy", LW'(busy), '0);
    chk("rst_mid_line", rd_line, '0);
    repeat (12) begin
      next_cyc();
      chk("rst_no_done", LW'({done, busy, dqs_oe}), '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
